exe_alu_stage: RTL and testbench
================================

# exe_alu_stage

Execute stage of the pipelined ARM-subset core. It consumes Val1 (Rn) and Val2, the second operand produced by the operand-2 generator, and executes the ALU command decoded in ID. It also maintains the NZCV status register and computes the branch target. Results are latched into the EX/MEM pipeline register for the memory stage.

## Interface
Parameters:
- WIDTH, 32, datapath width (only 32 is supported)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hold the EX/MEM register and the status register
- flush  in  1  insert a bubble into the EX/MEM register
- exe_cmd  in  4  ALU command
- s_bit  in  1  update the status register
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from ID/EX
- b_in  in  1  branch instruction
- dest_in  in  4  destination register
- pc_in  in  32  PC+4 of the instruction
- signed_imm_24  in  24  branch offset in words
- val1  in  32  Rn value
- val2  in  32  operand-2 value
- val_rm_in  in  32  Rm value (store data)
- alu_res  out  32  registered ALU result
- val_rm  out  32  registered store data
- dest  out  4  registered destination register
- wb_en, mem_r_en, mem_w_en  out  1 each  registered control bits
- status  out  4  NZCV register: {N,Z,C,V}
- branch_taken  out  1  combinational, equal to b_in
- branch_addr  out  32  combinational, pc_in + sign_extend(signed_imm_24) << 2

## Operation
- ALU commands (exe_cmd):
  - MOV 0001: val2
  - MVN 1001: ~val2
  - ADD/LDR/STR 0010: val1 + val2
  - ADC 0011: val1 + val2 + C
  - SUB/CMP 0100: val1 − val2
  - SBC 0101: val1 − val2 − !C
  - AND/TST 0110: val1 & val2
  - ORR 0111: val1 | val2
  - EOR 1000: val1 ^ val2
  - Any other code: result 0, flags NZ from 0, C and V unchanged.
- Arithmetic runs in 33 bits. C is bit 32 of the sum. For subtraction, C is the inverted borrow, so C=1 means no borrow.
- V is signed overflow:
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from val1.
- Logic and move commands:
  - Update only N and Z.
  - C and V keep their stored values.
- N is result[31]; Z is (result == 0).
- The carry-in for ADC/SBC is the C bit currently registered in status, before this cycle's update.
- Status register:
  - Loads the new flags at the clock edge when s_bit=1, freeze=0 and flush=0.
  - Otherwise it holds.
- EX/MEM register priority: rst > freeze > flush > load.
  - freeze: every registered output holds.
  - flush: wb_en, mem_r_en and mem_w_en clear to 0; data fields are don't-care but are cleared to 0.
- If freeze and flush are both high, freeze wins and nothing changes.

## Timing
- Reset (asynchronous, immediate): alu_res, val_rm, dest, wb_en, mem_r_en, mem_w_en and status are all 0.
- Latency:
  - One cycle from the operands to alu_res and the control outputs.
  - Status is visible the cycle after the edge that loads it.
- branch_taken and branch_addr are combinational, with zero latency, so the fetch stage can redirect in the same cycle.
- Back-to-back ADC: the second ADC sees the carry written by the first, because status is loaded at the first edge.
- Reset asserted mid-operation: all state clears immediately. The first edge after deassertion loads normally.

## Configuration
- EXE_CARRY_OPS_EN:
  - Defined: ADC and SBC behave as specified above.
  - Undefined: ADC decodes as ADD and SBC decodes as SUB. Carry-in logic is omitted and the C flag is still produced.

## Structure
- Shared package exe_pkg holds:
  - exe_cmd localparams (EXE_MOV … EXE_EOR)
  - status bit indices (N=3, Z=2, C=1, V=0)
- Sub-module exe_alu: purely combinational, taking (val1, val2, cmd, c_in) and producing (result, nzcv_next, nzcv_mask).
- The top level holds the status register, the EX/MEM register and the branch adder.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately, status=0000.
- ADD with S: val1=0x7FFFFFFF, val2=1, cmd=0010, s=1 -> alu_res=0x80000000, status=1001 (N,V).
- SUB to zero: val1=5, val2=5, cmd=0100, s=1 -> alu_res=0, status=0110 (Z,C). Then ADC 1+1 -> alu_res=3.
- Logic keeps C/V: with status=0011, AND 0xF0&0x0F, s=1 -> status=0111.
- Freeze/flush: freeze=1 holds all outputs across 3 cycles. flush=1 with wb_en_in=1 -> wb_en=0 next cycle and status unchanged.
- Branch: pc_in=0x100, signed_imm_24=0xFFFFFE, b_in=1 -> branch_taken=1, branch_addr=0xF8 in the same cycle.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command codes, NZCV bit indices and flag masks.
// EXE_CARRY_OPS_EN (optional) enables the carry-in forms ADC/SBC; see exe_alu.sv.
package exe_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] MASK_ALL = 4'b1111;
    localparam logic [3:0] MASK_NZ  = 4'b1100;

    typedef enum logic [1:0] {
        ALU_LOGIC = 2'd0,
        ALU_ADD   = 2'd1,
        ALU_SUB   = 2'd2
    } alu_op_e;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU: result, candidate NZCV flags and the mask of flags the command may update.
// Macro EXE_CARRY_OPS_EN: when defined ADC/SBC use c_in; otherwise they decode as ADD/SUB.
module exe_alu
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [3:0]       cmd,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv_next,
    output logic [3:0]       nzcv_mask
);

    alu_op_e          op;
    logic             carry_in;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH:0]   sum;

`ifndef EXE_CARRY_OPS_EN
    logic unused_c_in;
    assign unused_c_in = c_in;
`endif

    always_comb begin
        op       = ALU_LOGIC;
        carry_in = 1'b0;
        result   = '0;
        case (cmd)
            EXE_MOV: result = val2;
            EXE_MVN: result = ~val2;
            EXE_AND: result = val1 & val2;
            EXE_ORR: result = val1 | val2;
            EXE_EOR: result = val1 ^ val2;
            EXE_ADD: op = ALU_ADD;
            EXE_SUB: begin
                op       = ALU_SUB;
                carry_in = 1'b1;
            end
`ifdef EXE_CARRY_OPS_EN
            EXE_ADC: begin
                op       = ALU_ADD;
                carry_in = c_in;
            end
            // a - b - !C is a + ~b + C
            EXE_SBC: begin
                op       = ALU_SUB;
                carry_in = c_in;
            end
`else
            EXE_ADC: op = ALU_ADD;
            EXE_SBC: begin
                op       = ALU_SUB;
                carry_in = 1'b1;
            end
`endif
            default: result = '0;
        endcase

        operand_b = (op == ALU_SUB) ? ~val2 : val2;
        sum       = {1'b0, val1} + {1'b0, operand_b} + {{WIDTH{1'b0}}, carry_in};

        nzcv_mask = MASK_NZ;
        if (op != ALU_LOGIC) begin
            result    = sum[WIDTH-1:0];
            nzcv_mask = MASK_ALL;
        end

        // With b inverted for subtraction, carry-out is the inverted borrow and one overflow rule covers both
        nzcv_next         = '0;
        nzcv_next[FLAG_N] = result[WIDTH-1];
        nzcv_next[FLAG_Z] = (result == '0);
        nzcv_next[FLAG_C] = sum[WIDTH];
        nzcv_next[FLAG_V] = (val1[WIDTH-1] == operand_b[WIDTH-1]) &&
                            (result[WIDTH-1] != val1[WIDTH-1]);
    end

endmodule

// File: rtl/exe_alu_stage.sv
// Execute stage: ALU, NZCV status register, EX/MEM pipeline register and branch-target adder.
// Macro EXE_CARRY_OPS_EN selects carry-in ADC/SBC inside exe_alu.
module exe_alu_stage
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [3:0]       exe_cmd,
    input  logic             s_bit,
    input  logic             wb_en_in,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic             b_in,
    input  logic [3:0]       dest_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [23:0]      signed_imm_24,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] val_rm_in,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] val_rm,
    output logic [3:0]       dest,
    output logic             wb_en,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic [3:0]       status,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_addr
);

    logic [WIDTH-1:0] alu_result;
    logic [3:0]       nzcv_next;
    logic [3:0]       nzcv_mask;

    logic [WIDTH-1:0] alu_res_q, alu_res_d;
    logic [WIDTH-1:0] val_rm_q, val_rm_d;
    logic [3:0]       dest_q, dest_d;
    logic             wb_en_q, wb_en_d;
    logic             mem_r_en_q, mem_r_en_d;
    logic             mem_w_en_q, mem_w_en_d;
    logic [3:0]       status_q, status_d;

    exe_alu #(.WIDTH(WIDTH)) u_alu (
        .val1      (val1),
        .val2      (val2),
        .cmd       (exe_cmd),
        .c_in      (status_q[FLAG_C]),
        .result    (alu_result),
        .nzcv_next (nzcv_next),
        .nzcv_mask (nzcv_mask)
    );

    // Freeze outranks flush; a flushed slot never touches the flags
    always_comb begin
        alu_res_d  = alu_res_q;
        val_rm_d   = val_rm_q;
        dest_d     = dest_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        status_d   = status_q;
        if (!freeze) begin
            if (flush) begin
                alu_res_d  = '0;
                val_rm_d   = '0;
                dest_d     = '0;
                wb_en_d    = 1'b0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
            end else begin
                alu_res_d  = alu_result;
                val_rm_d   = val_rm_in;
                dest_d     = dest_in;
                wb_en_d    = wb_en_in;
                mem_r_en_d = mem_r_en_in;
                mem_w_en_d = mem_w_en_in;
                if (s_bit) begin
                    status_d = (nzcv_next & nzcv_mask) | (status_q & ~nzcv_mask);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            status_q   <= '0;
        end else begin
            alu_res_q  <= alu_res_d;
            val_rm_q   <= val_rm_d;
            dest_q     <= dest_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            status_q   <= status_d;
        end
    end

    assign alu_res  = alu_res_q;
    assign val_rm   = val_rm_q;
    assign dest     = dest_q;
    assign wb_en    = wb_en_q;
    assign mem_r_en = mem_r_en_q;
    assign mem_w_en = mem_w_en_q;
    assign status   = status_q;

    // Word offset to byte offset, sign-extended so fetch can redirect this cycle
    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(WIDTH-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_alu_stage.sv
// Self-checking bench for exe_alu_stage: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_exe_alu_stage;

`ifdef EXE_CARRY_OPS_EN
    localparam bit CARRY_OPS = 1'b1;
`else
    localparam bit CARRY_OPS = 1'b0;
`endif

    localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001, C_ADD = 4'b0010, C_ADC = 4'b0011;
    localparam logic [3:0] C_SUB = 4'b0100, C_SBC = 4'b0101, C_AND = 4'b0110, C_ORR = 4'b0111;
    localparam logic [3:0] C_EOR = 4'b1000, C_BAD = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0, flush = 1'b0, s_bit = 1'b0;
    logic [3:0]  exe_cmd = '0, dest_in = '0;
    logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, b_in = 1'b0;
    logic [31:0] pc_in = '0, val1 = '0, val2 = '0, val_rm_in = '0;
    logic [23:0] signed_imm_24 = '0;
    logic [31:0] alu_res, val_rm, branch_addr;
    logic [3:0]  dest, status;
    logic        wb_en, mem_r_en, mem_w_en, branch_taken;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    exe_alu_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .exe_cmd(exe_cmd), .s_bit(s_bit),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .dest_in(dest_in), .pc_in(pc_in), .signed_imm_24(signed_imm_24),
        .val1(val1), .val2(val2), .val_rm_in(val_rm_in),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .status(status), .branch_taken(branch_taken), .branch_addr(branch_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: flags derived from plain 64-bit unsigned/signed arithmetic
    function automatic void modelExec(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] st, output logic [31:0] r, output logic [3:0] fl);
        longint ua, ub, sa, sb, u, s, cin, bor;
        bit arith, is_sub;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cin = (CARRY_OPS && st[1]) ? 64'sd1 : 64'sd0;
        bor = (CARRY_OPS && !st[1]) ? 64'sd1 : 64'sd0;
        u = 0; s = 0; arith = 0; is_sub = 0;
        r = '0;
        fl = st;
        case (cmd)
            C_MOV: r = b;
            C_MVN: r = ~b;
            C_AND: r = a & b;
            C_ORR: r = a | b;
            C_EOR: r = a ^ b;
            C_ADD: begin u = ua + ub;       s = sa + sb;       arith = 1; end
            C_ADC: begin u = ua + ub + cin; s = sa + sb + cin; arith = 1; end
            C_SUB: begin u = ua - ub;       s = sa - sb;       arith = 1; is_sub = 1; end
            C_SBC: begin u = ua - ub - bor; s = sa - sb - bor; arith = 1; is_sub = 1; end
            default: r = '0;
        endcase
        if (arith) begin
            r = u[31:0];
            fl[1] = is_sub ? (u >= 64'sd0) : (u >= 64'sd4294967296);
            fl[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        fl[3] = r[31];
        fl[2] = (r == 32'd0);
    endfunction

    logic [31:0] m_alu = '0, m_rm = '0, m_r;
    logic [3:0]  m_dest = '0, m_status = '0, m_fl;
    logic        m_wb = 1'b0, m_mr = 1'b0, m_mw = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_alu = '0; m_rm = '0; m_dest = '0; m_status = '0;
            m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        end else if (!freeze) begin
            if (flush) begin
                m_alu = '0; m_rm = '0; m_dest = '0;
                m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
            end else begin
                modelExec(exe_cmd, val1, val2, m_status, m_r, m_fl);
                m_alu = m_r; m_rm = val_rm_in; m_dest = dest_in;
                m_wb = wb_en_in; m_mr = mem_r_en_in; m_mw = mem_w_en_in;
                if (s_bit) m_status = m_fl;
            end
        end
    end

    logic [31:0] exp_baddr;
    always @(negedge clk) begin
        if (checking && !rst) begin
            exp_baddr = 32'(longint'(pc_in) + longint'($signed(signed_imm_24)) * 64'sd4);
            checkOutput("model alu_res", alu_res, m_alu);
            checkOutput("model val_rm", val_rm, m_rm);
            checkOutput("model dest", 32'(dest), 32'(m_dest));
            checkOutput("model wb_en", 32'(wb_en), 32'(m_wb));
            checkOutput("model mem_r_en", 32'(mem_r_en), 32'(m_mr));
            checkOutput("model mem_w_en", 32'(mem_w_en), 32'(m_mw));
            checkOutput("model status", 32'(status), 32'(m_status));
            checkOutput("model branch_taken", 32'(branch_taken), 32'(b_in));
            checkOutput("model branch_addr", branch_addr, exp_baddr);
        end
    end

    // Called just after an active edge; drives the next operation and returns just after its edge
    task automatic applyStimulus(input logic [3:0] cmd, input logic s, input logic [31:0] a, input logic [31:0] b);
        exe_cmd       = cmd;
        s_bit         = s;
        val1          = a;
        val2          = b;
        val_rm_in     = ~a;
        pc_in         = pc_in + 32'd4;
        signed_imm_24 = b[23:0] ^ 24'h800001;
        b_in          = a[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        checkOutput("reset alu_res", alu_res, 32'h0);
        checkOutput("reset status", 32'(status), 32'h0);
        checkOutput("reset wb_en", 32'(wb_en), 32'h0);
        checkOutput("reset dest", 32'(dest), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        wb_en_in = 1'b1;
        dest_in = 4'h3;

        applyStimulus(C_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1);
        checkOutput("add overflow alu_res", alu_res, 32'h8000_0000);
        checkOutput("add overflow status", 32'(status), 32'h9);
        checkOutput("add val_rm", val_rm, 32'h8000_0000);
        checkOutput("add dest", 32'(dest), 32'h3);
        checkOutput("add wb_en", 32'(wb_en), 32'h1);

        applyStimulus(C_SUB, 1'b1, 32'd5, 32'd5);
        checkOutput("sub zero alu_res", alu_res, 32'h0);
        checkOutput("sub zero status", 32'(status), 32'h6);

        applyStimulus(C_ADC, 1'b1, 32'd1, 32'd1);
        checkOutput("adc after sub alu_res", alu_res, CARRY_OPS ? 32'd3 : 32'd2);
        checkOutput("adc after sub status", 32'(status), 32'h0);

        applyStimulus(C_ADD, 1'b1, 32'h8000_0000, 32'h8000_0001);
        checkOutput("add carry+ovf status", 32'(status), 32'h3);

        applyStimulus(C_AND, 1'b1, 32'hF0, 32'h0F);
        checkOutput("and alu_res", alu_res, 32'h0);
        checkOutput("and keeps CV status", 32'(status), 32'h7);

        applyStimulus(C_ADC, 1'b1, 32'hFFFF_FFFF, 32'h1);
        checkOutput("adc wrap alu_res", alu_res, CARRY_OPS ? 32'h1 : 32'h0);
        checkOutput("adc wrap status", 32'(status), CARRY_OPS ? 32'h2 : 32'h6);

        applyStimulus(C_ADC, 1'b1, 32'd1, 32'd1);
        checkOutput("adc back-to-back alu_res", alu_res, CARRY_OPS ? 32'd3 : 32'd2);

        applyStimulus(C_SBC, 1'b1, 32'd10, 32'd3);
        checkOutput("sbc alu_res", alu_res, CARRY_OPS ? 32'd6 : 32'd7);
        checkOutput("sbc status", 32'(status), 32'h2);

        applyStimulus(C_MVN, 1'b0, 32'h0, 32'h0);
        checkOutput("mvn alu_res", alu_res, 32'hFFFF_FFFF);
        checkOutput("mvn no-s status", 32'(status), 32'h2);

        applyStimulus(C_ORR, 1'b1, 32'hF0, 32'h0F);
        checkOutput("orr alu_res", alu_res, 32'hFF);

        applyStimulus(C_EOR, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
        checkOutput("eor status", 32'(status), 32'hA);

        applyStimulus(C_MOV, 1'b1, 32'h1234, 32'h0);
        checkOutput("mov zero status", 32'(status), 32'h6);

        applyStimulus(C_SUB, 1'b1, 32'h0, 32'h1);
        checkOutput("sub borrow alu_res", alu_res, 32'hFFFF_FFFF);
        checkOutput("sub borrow status", 32'(status), 32'h8);

        applyStimulus(C_BAD, 1'b1, 32'd5, 32'd7);
        checkOutput("bad cmd alu_res", alu_res, 32'h0);
        checkOutput("bad cmd status", 32'(status), 32'h4);

        applyStimulus(C_ADD, 1'b0, 32'd1, 32'd2);
        checkOutput("load alu_res", alu_res, 32'd3);

        freeze = 1'b1;
        wb_en_in = 1'b0;
        dest_in = 4'h9;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(C_ADD, 1'b1, 32'd10, 32'd20);
            checkOutput("freeze alu_res", alu_res, 32'd3);
            checkOutput("freeze status", 32'(status), 32'h4);
            checkOutput("freeze wb_en", 32'(wb_en), 32'h1);
            checkOutput("freeze dest", 32'(dest), 32'h3);
        end

        flush = 1'b1;
        applyStimulus(C_ADD, 1'b1, 32'd10, 32'd20);
        checkOutput("freeze+flush alu_res", alu_res, 32'd3);
        checkOutput("freeze+flush wb_en", 32'(wb_en), 32'h1);

        freeze = 1'b0;
        wb_en_in = 1'b1;
        mem_r_en_in = 1'b1;
        applyStimulus(C_ADD, 1'b1, 32'd10, 32'd20);
        checkOutput("flush wb_en", 32'(wb_en), 32'h0);
        checkOutput("flush mem_r_en", 32'(mem_r_en), 32'h0);
        checkOutput("flush alu_res", alu_res, 32'h0);
        checkOutput("flush status", 32'(status), 32'h4);

        flush = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b1;
        dest_in = 4'h5;
        applyStimulus(C_ADD, 1'b1, 32'd2, 32'd3);
        checkOutput("store alu_res", alu_res, 32'd5);
        checkOutput("store mem_w_en", 32'(mem_w_en), 32'h1);
        checkOutput("store status", 32'(status), 32'h0);

        pc_in = 32'h100;
        signed_imm_24 = 24'hFFFFFE;
        b_in = 1'b1;
        #1;
        checkOutput("branch_taken", 32'(branch_taken), 32'h1);
        checkOutput("branch_addr", branch_addr, 32'hF8);
        @(posedge clk);
        #1;

        #2 rst = 1'b1;
        #1;
        checkOutput("mid reset alu_res", alu_res, 32'h0);
        checkOutput("mid reset status", 32'(status), 32'h0);
        checkOutput("mid reset mem_w_en", 32'(mem_w_en), 32'h0);
        checkOutput("mid reset dest", 32'(dest), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(C_SUB, 1'b1, 32'd9, 32'd4);
        checkOutput("post reset alu_res", alu_res, 32'd5);
        checkOutput("post reset status", 32'(status), 32'h2);

        @(posedge clk);
        #1;
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
